sar_search: RTL
===============

# sar_search

Successive-approximation search engine that finds an unknown WIDTH-bit value by driving trial values into a magnitude comparator and steering on its `less`/`equal`/`greater` outcome. The block drives the comparator's `DinA` port; the unknown value sits on `DinB`. It consumes the comparator's three result flags and reports the located value, or an error.

## Interface
- `WIDTH`, default 4: width of the trial value and of the result.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a search; sampled only in IDLE.
- `Dout` output WIDTH: registered trial value, wired to the comparator's `DinA`.
- `less` input 1: comparator flag, trial < target.
- `equal` input 1: comparator flag, trial == target.
- `greater` input 1: comparator flag, trial > target.
- `busy` output 1: high in DRIVE and COMPARE.
- `done` output 1: one-cycle pulse when the search ends.
- `err` output 1: qualified by `done`; target not found, or the flags were invalid.
- `result` output WIDTH: located value; held from `done` until the next accepted `start`.

## Operation
- Internal bounds `lo` and `hi` are WIDTH+1 bits wide and unsigned. The trial value is `mid = (lo + hi) >> 1`, computed at WIDTH+2 bits and truncated to WIDTH.
- IDLE: `busy`=0. On `start`=1:
  - `lo`=0, `hi`=2^WIDTH-1.
  - `Dout`=2^(WIDTH-1)-1 (7 for WIDTH=4).
  - Go to DRIVE.
- DRIVE: settle cycle for the comparator; unconditionally go to COMPARE.
- COMPARE: sample the flags.
  - Exactly `equal`: `result`=`Dout`, `err`=0, go to DONE.
  - Exactly `less`:
    - If `Dout`==2^WIDTH-1: `err`=1, go to DONE.
    - Otherwise `lo`=`Dout`+1.
  - Exactly `greater`:
    - If `Dout`==0: `err`=1, go to DONE.
    - Otherwise `hi`=`Dout`-1.
  - After a `less` or `greater` update, if the new `lo` > `hi`: `err`=1, go to DONE. Otherwise load `Dout` with the new mid and go to DRIVE.
  - Flags not one-hot (none set, or more than one set): `err`=1, go to DONE.
- DONE: `done`=1 for this cycle only; go to IDLE.
- On an error exit, `result` keeps the last trial value.
- `start` is ignored in DRIVE, COMPARE and DONE. It is not queued.
- `Dout` holds its last trial value in IDLE and DONE.
- If the target changes mid-search, the block keeps searching with its current bounds. It either finds the new value or exits with `err`.

## Timing
- Reset values: state=IDLE; `Dout`=0, `busy`=0, `done`=0, `err`=0, `result`=0, `lo`=0, `hi`=0.
- Reset mid-search aborts the search on the next edge. No `done` is produced.
- Each trial takes 2 cycles (DRIVE, then COMPARE).
- A search that needs N trials asserts `done` in the cycle following the 2N-th rising edge after the edge that sampled `start`.
- Maximum N is WIDTH+1 (5 for WIDTH=4), so worst-case latency is 2·WIDTH+2 edges.
- `busy` rises on the edge that samples `start` and falls on the edge that enters DONE.
- The earliest next `start` is accepted on the edge after `done`, which is the IDLE cycle.
- The comparator is assumed combinational: the flags are valid by the end of DRIVE and are sampled on the closing edge of COMPARE.

## Test plan
All cases use WIDTH=4 with a behavioural comparator between `Dout` and the target.

1. **Reset defaults:** assert `rst` for 2 cycles -> all outputs 0, `busy`=0.
2. **Immediate hit:** target 7, pulse `start` -> `Dout`=7, `done` 2 edges later, `result`=7, `err`=0.
3. **Upper edge:** target 15 -> `Dout` sequence 7, 11, 13, 14, 15; `done` after 10 edges; `result`=15.
4. **Lower edge:** target 0 -> `Dout` sequence 7, 3, 1, 0; `done` after 8 edges; `result`=0.
5. **Sweep:** targets 0..15 -> `result`==target, `err`=0, latency ≤10 edges.
6. **Faults and aborts:**
   - Force `less`=`greater`=1 in COMPARE -> `done`=1 with `err`=1.
   - Change target 5→12 mid-search -> ends with `result`=12 or `err`=1, never a wrong value with `err`=0.
   - Assert `rst` during COMPARE -> IDLE with no `done`.
   - Pulse `start` while `busy` -> ignored.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial values into an external magnitude
// comparator and narrows [lo, hi] on its less/equal/greater flags until it hits or fails.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] Dout,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CMP, S_DONE} state_t;

    localparam logic [WIDTH:0]   HI_INIT  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MID_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   ONE      = {{WIDTH{1'b0}}, 1'b1};

    state_t           r_state, w_next;
    logic [WIDTH:0]   r_lo, r_hi;
    logic [WIDTH-1:0] r_dout, r_result;
    logic             r_err;

    logic             w_onehot, w_hit, w_fail;
    logic [WIDTH:0]   w_dout_ext, w_new_lo, w_new_hi;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH-1:0] w_mid;

    assign w_onehot   = ({less, equal, greater} == 3'b100) ||
                        ({less, equal, greater} == 3'b010) ||
                        ({less, equal, greater} == 3'b001);
    assign w_hit      = w_onehot && equal;
    assign w_dout_ext = {1'b0, r_dout};

    // Bound update and exit decision for the COMPARE cycle.
    always_comb begin
        w_new_lo = r_lo;
        w_new_hi = r_hi;
        w_fail   = 1'b0;
        if (!w_onehot) begin
            w_fail = 1'b1;
        end else if (less) begin
            if (r_dout == {WIDTH{1'b1}}) w_fail = 1'b1;
            else                         w_new_lo = w_dout_ext + ONE;
        end else if (greater) begin
            if (r_dout == {WIDTH{1'b0}}) w_fail = 1'b1;
            else                         w_new_hi = w_dout_ext - ONE;
        end
        if (!w_fail && !w_hit && (w_new_lo > w_new_hi)) w_fail = 1'b1;
        w_sum = {1'b0, w_new_lo} + {1'b0, w_new_hi};
        w_mid = w_sum[WIDTH:1];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRIVE;
            S_DRIVE: w_next = S_CMP;
            S_CMP:   w_next = (w_hit || w_fail) ? S_DONE : S_DRIVE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_DRIVE) || (r_state == S_CMP);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_dout   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_lo   <= '0;
                    r_hi   <= HI_INIT;
                    r_dout <= MID_INIT;
                    r_err  <= 1'b0;
                end
                S_CMP: if (w_hit || w_fail) begin
                    // Error exits also report the last trial value.
                    r_result <= r_dout;
                    r_err    <= w_fail;
                end else begin
                    r_lo   <= w_new_lo;
                    r_hi   <= w_new_hi;
                    r_dout <= w_mid;
                end
                default: ;
            endcase
        end
    end

    assign Dout   = r_dout;
    assign result = r_result;
    assign err    = r_err;

endmodule
